// File: rtl/median_axis_pkg.sv
// Shared types for the median filter AXI4-Stream output buffer.
// axis_beat_t is the beat layout at the filter's native pixel width.
package median_axis_pkg;

   localparam int unsigned PIX_WIDTH = 8;

   typedef struct packed {
      logic                 tuser;
      logic                 tlast;
      logic [PIX_WIDTH-1:0] tdata;
   } axis_beat_t;

   typedef enum logic [0:0] {
      PASS,
      DROP
   } fifo_state_t;

endpackage

// File: rtl/median_axis_out_fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Reading an address written in the same cycle returns the old contents.
module sdp_ram #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/median_axis_out_fifo.sv
// Output buffer behind the median filter: turns a valid-only pixel stream into an AXI4-Stream
// master, dropping whole frames on overflow until the next start-of-frame.
module median_axis_out_fifo
   import median_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned AFULL_LEVEL = DEPTH - 16
) (
   input  logic                  i_clk,
   input  logic                  i_aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   input  logic                  i_clr_overflow,
   output logic                  o_overflow,
   output logic                  o_almost_full,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned BW = DATA_WIDTH + 2;
   localparam logic [AW:0] AFULL_LVL = AFULL_LEVEL[AW:0];

   fifo_state_t state_q;

   logic [AW:0]           wr_ptr_q, rd_ptr_q, rd_ptr_d, level_q;
   logic                  mem_empty, mem_full, pop, space, we, pass_drop;
   logic                  byp_q, byp_d;
   logic [BW-1:0]         wr_beat, ram_rdata, byp_beat_q, head;
   logic                  m_tvalid_q, m_tuser_q, m_tlast_q;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic                  ovf_q, afull_q;

   assign wr_beat = {s_axis_tuser, s_axis_tlast, s_axis_tdata};

   always_comb begin
      mem_empty = (wr_ptr_q == rd_ptr_q);
      mem_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop       = !mem_empty && (!m_tvalid_q || m_axis_tready);
      space     = !mem_full || pop;
      // While dropping, only a start-of-frame beat is allowed to resynchronise.
      we        = s_axis_tvalid && space && ((state_q == PASS) || s_axis_tuser);
      pass_drop = s_axis_tvalid && !space && (state_q == PASS);
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
      // The RAM read lags a cycle, so a write landing on the next head is forwarded directly.
      byp_d     = we && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
      head      = byp_q ? byp_beat_q : ram_rdata;
   end

   sdp_ram #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (i_clk),
      .we_i    (we),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_beat),
      .raddr_i (rd_ptr_d[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         afull_q    <= 1'b0;
         byp_q      <= 1'b0;
         byp_beat_q <= '0;
      end else begin
         if (we) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_q + {{AW{1'b0}}, we} - {{AW{1'b0}}, pop};
         afull_q    <= (level_q >= AFULL_LVL);
         byp_q      <= byp_d;
         byp_beat_q <= wr_beat;
      end
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= PASS;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            PASS: begin
               if (pass_drop) begin
                  state_q <= DROP;
               end
            end
            DROP: begin
               if (s_axis_tvalid && s_axis_tuser && space) begin
                  state_q <= PASS;
               end
            end
            default: state_q <= PASS;
         endcase
         if (pass_drop) begin
            ovf_q <= 1'b1;
         end else if (i_clr_overflow) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         m_tvalid_q <= 1'b0;
         m_tuser_q  <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
      end else if (pop) begin
         m_tvalid_q                         <= 1'b1;
         {m_tuser_q, m_tlast_q, m_tdata_q}  <= head;
      end else if (m_axis_tready) begin
         m_tvalid_q <= 1'b0;
      end
   end

   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tuser  = m_tuser_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tdata  = m_tdata_q;
   assign o_overflow    = ovf_q;
   assign o_almost_full = afull_q;
   assign o_level       = level_q;

endmodule

// File: tb/tb_median_axis_out_fifo.sv
// Directed bench for median_axis_out_fifo at DEPTH=16, AFULL_LEVEL=12.
module tb_median_axis_out_fifo;
   import median_axis_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid, s_tuser, s_tlast;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid, m_tuser, m_tlast, m_tready;
   logic          clr, ovf, afull;
   logic [4:0]    level;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;
   int max_level = 0;
   axis_beat_t exp_q[$];

   median_axis_out_fifo #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (12)
   ) dut (
      .i_clk          (clk),
      .i_aresetn      (rst_n),
      .s_axis_tdata   (s_tdata),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tuser   (s_tuser),
      .s_axis_tlast   (s_tlast),
      .m_axis_tdata   (m_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tuser   (m_tuser),
      .m_axis_tlast   (m_tlast),
      .m_axis_tready  (m_tready),
      .i_clr_overflow (clr),
      .o_overflow     (ovf),
      .o_almost_full  (afull),
      .o_level        (level)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic u, input logic l, input logic [7:0] d, input logic keep);
      s_tvalid = 1'b1;
      s_tuser  = u;
      s_tlast  = l;
      s_tdata  = d;
      if (keep) exp_q.push_back({u, l, d});
   endtask

   // One clock: score a handshake seen before the edge, then verify stall stability after it.
   task automatic tick();
      axis_beat_t held;
      logic       stall;
      held  = {m_tuser, m_tlast, m_tdata};
      stall = m_tvalid && !m_tready;
      if (m_tvalid && m_tready) begin
         check("rx_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("rx_beat", 32'(held), 32'(exp_q.pop_front()));
         rx_cnt++;
      end
      @(posedge clk);
      #1;
      if (int'(level) > max_level) max_level = int'(level);
      if (stall) begin
         check("stall_valid", 32'(m_tvalid), 32'd1);
         check("stall_hold", 32'({m_tuser, m_tlast, m_tdata}), 32'(held));
      end
   endtask

   task automatic drain(input int budget, input string tag);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; m_tready = 1'b0; clr = 1'b0;
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
      #2;
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tdata", 32'({m_tuser, m_tlast, m_tdata}), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_afull", 32'(afull), 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pass-through 8x4 frame with ready held high
      m_tready = 1'b1;
      rx_cnt   = 0;
      for (int i = 0; i < 32; i++) begin
         drive(i == 0, (i % 8) == 7, 8'(i), 1'b1);
         tick();
         if (i == 0) begin
            check("lat_valid_k", 32'(m_tvalid), 32'd0);
            check("lat_level_k", 32'(level), 32'd1);
         end
         if (i == 1) begin
            check("lat_valid_k1", 32'(m_tvalid), 32'd1);
            check("lat_sof", 32'({m_tuser, m_tdata}), 32'h100);
         end
         if (i == 31) check("pt_level_steady", 32'(level), 32'd1);
      end
      drain(8, "pt_drain");
      check("pt_count", 32'(rx_cnt), 32'd32);
      check("pt_level_end", 32'(level), 32'd0);

      // Backpressure: ready toggles 1010..., input bursty then half rate
      rx_cnt    = 0;
      max_level = 0;
      begin
         int sent;
         sent = 0;
         for (int c = 0; c < 200 && sent < 64; c++) begin
            m_tready = ((c % 2) == 0);
            if (c < 24 || (c % 2) == 0) begin
               drive(sent == 0, (sent % 8) == 7, 8'(sent + 128), 1'b1);
               sent++;
            end else begin
               s_tvalid = 1'b0;
            end
            tick();
         end
      end
      drain(40, "bp_drain");
      check("bp_count", 32'(rx_cnt), 32'd64);
      check("bp_no_ovf", 32'(ovf), 32'd0);
      check("bp_peak_le16", 32'(max_level <= 16), 32'd1);
      check("bp_peak_rose", 32'(max_level >= 8), 32'd1);

      // Fill to 16 with ready low, then write and pop in the same cycle
      rx_cnt   = 0;
      m_tready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(i == 0, 1'b0, 8'(32 + i), 1'b1);
         tick();
      end
      check("full_level", 32'(level), 32'd16);
      check("full_afull", 32'(afull), 32'd1);
      m_tready = 1'b1;
      drive(1'b0, 1'b1, 8'h31, 1'b1);
      tick();
      check("full_pop_level", 32'(level), 32'd16);
      check("full_pop_ovf", 32'(ovf), 32'd0);
      drain(30, "full_drain");
      tick();
      check("full_count", 32'(rx_cnt), 32'd18);
      check("afull_clear", 32'(afull), 32'd0);

      // Overflow and resync on next frame; clear races a PASS drop
      rx_cnt   = 0;
      m_tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(i == 0, 1'b0, 8'(8'hA0 + i), i <= 16);
         clr = (i == 17) || (i == 18);
         tick();
         if (i == 16) begin
            check("ovf_level16", 32'(level), 32'd16);
            check("ovf_not_yet", 32'(ovf), 32'd0);
         end
         if (i == 17) check("ovf_set_wins", 32'(ovf), 32'd1);
         if (i == 18) check("ovf_clr", 32'(ovf), 32'd0);
         if (i == 19) check("ovf_drop_no_set", 32'(ovf), 32'd0);
      end
      clr      = 1'b0;
      m_tready = 1'b1;
      drive(1'b0, 1'b1, 8'hAF, 1'b0);
      tick();
      check("drop_discard_level", 32'(level), 32'd15);
      for (int j = 0; j < 8; j++) begin
         drive(j == 0, j == 7, 8'(8'hB0 + j), 1'b1);
         tick();
         if (j == 0) check("resync_level", 32'(level), 32'd15);
      end
      drain(40, "ovf_drain");
      check("ovf_count", 32'(rx_cnt), 32'd25);
      check("ovf_end", 32'(ovf), 32'd0);

      // Asynchronous reset with 10 beats queued
      m_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(i == 0, 1'b0, 8'(8'h60 + i), 1'b0);
         tick();
      end
      check("rst_mid_level_pre", 32'(level), 32'd9);
      s_tvalid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_mid_tdata", 32'({m_tuser, m_tlast, m_tdata}), 32'd0);
      check("rst_mid_level", 32'(level), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      rx_cnt   = 0;
      m_tready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         drive(j == 0, j == 3, 8'(8'h70 + j), 1'b1);
         tick();
         if (j == 0) check("post_rst_level", 32'(level), 32'd1);
      end
      drain(10, "post_rst_drain");
      check("post_rst_count", 32'(rx_cnt), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/median_axis_out_fifo.md
# median_axis_out_fifo

Output buffer stage placed directly downstream of the 5x5 median filter top level. It accepts the filter's valid-only pixel stream (tdata/tuser/tlast, no backpressure possible upstream) and re-presents it as a full AXI4-Stream master that honours `m_axis_tready`. On overflow it drops whole frames until the next start-of-frame, so downstream never sees a torn frame.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `DEPTH`, 1024, memory entries; power of two, at least 4.
- `AFULL_LEVEL`, DEPTH-16, occupancy at or above which `o_almost_full` asserts.

- `i_clk`, in, 1, single clock.
- `i_aresetn`, in, 1, reset: asynchronous, active-low.
- `s_axis_tdata`, in, DATA_WIDTH, pixel from median filter.
- `s_axis_tvalid`, in, 1, beat present; no ready returned.
- `s_axis_tuser`, in, 1, start of frame (first pixel).
- `s_axis_tlast`, in, 1, end of line.
- `m_axis_tdata`, out, DATA_WIDTH, registered output pixel.
- `m_axis_tvalid`, out, 1, registered.
- `m_axis_tuser`, out, 1, registered.
- `m_axis_tlast`, out, 1, registered.
- `m_axis_tready`, in, 1, downstream ready.
- `i_clr_overflow`, in, 1, one-cycle pulse that clears `o_overflow`.
- `o_overflow`, out, 1, sticky: at least one beat dropped.
- `o_almost_full`, out, 1, registered occupancy >= AFULL_LEVEL.
- `o_level`, out, $clog2(DEPTH)+1, memory occupancy, output register excluded.

## Operation
- Storage is a simple dual-port memory of {tuser, tlast, tdata}. Write and read pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap naturally.
- Output register holds the head beat. `pop = !mem_empty && (!m_axis_tvalid || m_axis_tready)`. On pop, the memory head loads into the output register and `m_axis_tvalid` is set. A handshake with no pop clears `m_axis_tvalid`.
- `space = !mem_full || pop`. A full memory with a same-cycle pop accepts the write.
- FSM, two states:
  - PASS (reset state): a valid beat is written if `space`. If there is no space, the beat is dropped, `o_overflow` is set and the FSM goes to DROP.
  - DROP: every beat with tuser=0 is discarded. A beat with tuser=1 is handled by PASS rules that same cycle: written if `space` and the FSM returns to PASS, otherwise dropped and the FSM stays in DROP.
- Dropping in DROP does not re-set `o_overflow`. Only a drop in PASS sets it.
- Beats already queued, including the partial frame, still drain. Downstream uses `o_overflow` to discard that frame.
- `i_clr_overflow` clears the flag. If a PASS drop occurs in the same cycle, set wins.
- `o_level` increments on write and decrements on pop. Both in the same cycle leaves it unchanged. Range is 0..DEPTH.
- No tuser/tlast reconstruction: flags are stored and delivered unchanged.

## Timing
- Reset: `m_axis_tvalid`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `o_overflow`=0, `o_almost_full`=0, `o_level`=0, pointers 0, FSM=PASS. An asynchronous assert mid-frame discards all content immediately.
- Latency into an empty FIFO with `m_axis_tready`=1: beat sampled at edge k is written at edge k, popped at edge k+1, and `m_axis_tvalid` is high after edge k+1.
- Throughput: one beat per clock sustained while `m_axis_tready`=1.
- `m_axis_tdata` and flags hold stable while `m_axis_tvalid` && !`m_axis_tready`. `m_axis_tvalid` never deasserts without a handshake.
- `o_almost_full` updates one edge after `o_level`.
- Total buffering is DEPTH+1 beats: memory plus output register.

## Structure
- Package `median_axis_pkg`: typedef `axis_beat_t` packed {tuser, tlast, tdata[DATA_WIDTH-1:0]}; FSM enum `fifo_state_t` {PASS, DROP}.
- One sub-module `sdp_ram` (DEPTH x width, registered read, write-first not required). The inference-friendly memory is kept separate from the control logic.
- The read path accounts for the one-cycle RAM read latency via a prefetch of the next head, so the Timing figures hold.

## Test plan
- Pass-through: 8x4 frame, `m_axis_tready`=1 -> 32 beats out in order, tuser on beat 0, tlast on beats 7/15/23/31, first `m_axis_tvalid` two edges after first input.
- Backpressure: `m_axis_tready` toggles 1010... over a 64-beat burst with DEPTH=16 -> no drop, `o_level` peaks ≤16, output order preserved, data stable during stalls.
- Full + simultaneous pop: fill to `o_level`=16, then input and `m_axis_tready`=1 in the same cycle -> write accepted, `o_level` stays 16, `o_overflow`=0.
- Overflow/resync: DEPTH=16, `m_axis_tready`=0, 20 beats of frame A then frame B starting with tuser -> `o_overflow`=1 after beat 17, rest of A dropped. Once ready rises, B is accepted from its tuser beat and 16 A beats drain first.
- Clear vs set: `i_clr_overflow` pulse in the same cycle as a PASS drop -> `o_overflow` remains 1. A pulse alone next cycle -> 0.
- Reset mid-frame: assert `i_aresetn`=0 with 10 beats queued -> outputs 0 immediately. After release, a new frame passes with correct `o_level` counting from 0.
